// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, defaults and helpers for the hazard scoreboard.
package hazard_pkg;

    localparam int DEF_REG_AW     = 5;
    localparam int DEF_PIPE_DEPTH = 3;
    localparam int DEF_LOAD_STAGE = 2;
    localparam int FWD_REGFILE    = 0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_REG_AW-1:0] rd;
        logic                  regwrt;
        logic                  load;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    function automatic int clog2(input int v);
        clog2 = 1;
        while ((1 << clog2) < v) clog2++;
    endfunction

endpackage

// File: rtl/hz_mc_counter.sv
// hz_mc_counter: occupancy counter for the iterative multicycle unit.
module hz_mc_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] lat,
    output logic         busy
);

    logic [W-1:0] cnt;

    assign busy = cnt != '0;

    // A new load cannot arrive while busy because decode is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt <= '0;
        else if (busy) cnt <= cnt - 1'b1;
        else if (load) cnt <= lat;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard driving decode stall, issue and E-stage forward selects.
// Define HAZARD_MC_UNIT_EN to add the iterative multicycle unit interlock.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = DEF_REG_AW,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int LOAD_STAGE = DEF_LOAD_STAGE,
`ifdef HAZARD_MC_UNIT_EN
    parameter int MC_LAT_W   = 4,
`endif
    parameter int FWD_W      = clog2(PIPE_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dec_valid_i,
    input  logic [REG_AW-1:0]   rs1_d_i,
    input  logic [REG_AW-1:0]   rs2_d_i,
    input  logic                rs1_use_d_i,
    input  logic                rs2_use_d_i,
    input  logic [REG_AW-1:0]   rd_d_i,
    input  logic                regwrt_d_i,
    input  logic                load_d_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                issue_o,
    output logic                ex_valid_o,
    output logic [FWD_W-1:0]    fwd_a_o,
`ifdef HAZARD_MC_UNIT_EN
    input  logic                mc_d_i,
    input  logic [MC_LAT_W-1:0] mc_lat_d_i,
    output logic                mc_busy_o,
`endif
    output logic [FWD_W-1:0]    fwd_b_o
);

    entry_t                st [1:PIPE_DEPTH];
    entry_t                new_e;
    logic [PIPE_DEPTH-1:1] hit_a, hit_b;
    logic [FWD_W-1:0]      sel_a, sel_b;
    logic                  lu_a, lu_b;
    logic                  busy;

`ifdef HAZARD_MC_UNIT_EN
    hz_mc_counter #(.W(MC_LAT_W)) u_mc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (issue_o & mc_d_i),
        .lat   (mc_lat_d_i),
        .busy  (busy)
    );
    assign mc_busy_o = busy;
`else
    assign busy = 1'b0;
`endif

    // The writeback stage writes the regfile this cycle, so it is never a forward source.
    for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_match
        assign hit_a[k] = st[k].valid & st[k].regwrt & (st[k].rd == rs1_d_i) & (|rs1_d_i) & rs1_use_d_i;
        assign hit_b[k] = st[k].valid & st[k].regwrt & (st[k].rd == rs2_d_i) & (|rs2_d_i) & rs2_use_d_i;
    end

    // Scan oldest to youngest so the youngest producer overrides.
    always_comb begin
        sel_a = FWD_W'(FWD_REGFILE);
        sel_b = FWD_W'(FWD_REGFILE);
        lu_a  = 1'b0;
        lu_b  = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
            if (hit_a[k]) begin
                sel_a = FWD_W'(k);
                lu_a  = st[k].load && (k < LOAD_STAGE);
            end
            if (hit_b[k]) begin
                sel_b = FWD_W'(k);
                lu_b  = st[k].load && (k < LOAD_STAGE);
            end
        end
    end

    assign stall_o = busy | (dec_valid_i & (lu_a | lu_b) & ~flush_i);
    assign issue_o = dec_valid_i & ~stall_o & ~flush_i;
    assign new_e   = '{valid: issue_o, rd: rd_d_i, regwrt: regwrt_d_i, load: load_d_i};

    // While the multicycle unit is busy its instruction stays in stage 1 and bubbles drain behind it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) st[k] <= BUBBLE;
            ex_valid_o <= 1'b0;
            fwd_a_o    <= '0;
            fwd_b_o    <= '0;
        end else begin
            st[1] <= busy ? st[1] : new_e;
            st[2] <= busy ? BUBBLE : st[1];
            for (int k = 3; k <= PIPE_DEPTH; k++) st[k] <= st[k-1];
            ex_valid_o <= issue_o;
            fwd_a_o    <= issue_o ? sel_a : '0;
            fwd_b_o    <= issue_o ? sel_b : '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven directed bench for hazard_scoreboard (mc section under HAZARD_MC_UNIT_EN).
module tb_hazard_scoreboard;

    logic       clk, rst_i, dec_valid_i, rs1_use_d_i, rs2_use_d_i, regwrt_d_i, load_d_i, flush_i;
    logic [4:0] rs1_d_i, rs2_d_i, rd_d_i;
    logic       stall_o, issue_o, ex_valid_o;
    logic [1:0] fwd_a_o, fwd_b_o;
`ifdef HAZARD_MC_UNIT_EN
    logic       mc_d_i, mc_busy_o;
    logic [3:0] mc_lat_d_i;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dec_valid_i (dec_valid_i),
        .rs1_d_i     (rs1_d_i),
        .rs2_d_i     (rs2_d_i),
        .rs1_use_d_i (rs1_use_d_i),
        .rs2_use_d_i (rs2_use_d_i),
        .rd_d_i      (rd_d_i),
        .regwrt_d_i  (regwrt_d_i),
        .load_d_i    (load_d_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .issue_o     (issue_o),
        .ex_valid_o  (ex_valid_o),
        .fwd_a_o     (fwd_a_o),
`ifdef HAZARD_MC_UNIT_EN
        .mc_d_i      (mc_d_i),
        .mc_lat_d_i  (mc_lat_d_i),
        .mc_busy_o   (mc_busy_o),
`endif
        .fwd_b_o     (fwd_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int v, rs1, rs2, u1, u2, rd, rw, ld, fl;
        int stall, issue, exv, fa, fb;
    } vec_t;

    vec_t vecs [29];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int is, input int ex, input int fa, input int fb);
        chk({tag, " stall"}, int'(stall_o), st);
        chk({tag, " issue"}, int'(issue_o), is);
        chk({tag, " ex_valid"}, int'(ex_valid_o), ex);
        chk({tag, " fwd_a"}, int'(fwd_a_o), fa);
        chk({tag, " fwd_b"}, int'(fwd_b_o), fb);
    endtask

    task automatic drive(input int v, input int rs1, input int rs2, input int u1, input int u2,
                         input int rd, input int rw, input int ld, input int fl);
        dec_valid_i = v[0];
        rs1_d_i     = 5'(rs1);
        rs2_d_i     = 5'(rs2);
        rs1_use_d_i = u1[0];
        rs2_use_d_i = u2[0];
        rd_d_i      = 5'(rd);
        regwrt_d_i  = rw[0];
        load_d_i    = ld[0];
        flush_i     = fl[0];
`ifdef HAZARD_MC_UNIT_EN
        mc_d_i      = 1'b0;
        mc_lat_d_i  = 4'd0;
`endif
    endtask

    initial begin
        //          v rs1 rs2 u1 u2 rd rw ld fl  st is ex fa fb
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 1, 0, 0, 0};
        vecs[2]  = '{1, 5, 1, 1, 1, 6, 1, 0, 0,  0, 1, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0};
        vecs[4]  = '{1, 1, 0, 1, 0, 7, 1, 1, 0,  0, 1, 0, 0, 0};
        vecs[5]  = '{1, 7, 7, 1, 1, 8, 1, 0, 0,  1, 0, 1, 0, 0};
        vecs[6]  = '{1, 7, 7, 1, 1, 8, 1, 0, 0,  0, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 2};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 1, 1, 1, 1, 0, 0,  0, 1, 1, 0, 0};
        vecs[10] = '{1, 3, 4, 1, 1, 9, 1, 0, 0,  0, 1, 1, 0, 0};
        vecs[11] = '{1, 3, 9, 1, 0, 10, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[12] = '{1, 9, 9, 1, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 2};
        vecs[14] = '{1, 1, 0, 1, 0, 11, 1, 1, 0, 0, 1, 0, 0, 0};
        vecs[15] = '{1, 11, 0, 1, 1, 12, 1, 0, 1, 0, 0, 1, 0, 0};
        vecs[16] = '{1, 12, 12, 1, 1, 13, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        vecs[18] = '{1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0, 0, 0, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[20] = '{1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[23] = '{1, 15, 15, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
        vecs[25] = '{1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[26] = '{1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 1, 1, 0, 0};
        vecs[27] = '{1, 16, 16, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[28] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1};

        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("in_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].fl);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].stall, vecs[i].issue, vecs[i].exv, vecs[i].fa, vecs[i].fb);
        end

        // Asynchronous reset with three loads in flight.
        @(negedge clk); drive(1, 0, 0, 0, 0, 20, 1, 1, 0);
        @(negedge clk); drive(1, 0, 0, 0, 0, 21, 1, 1, 0);
        @(negedge clk); drive(1, 0, 0, 0, 0, 22, 1, 1, 0);
        @(negedge clk); drive(1, 22, 21, 1, 1, 24, 1, 0, 0);
        #1;
        chk("pre_rst stall", int'(stall_o), 1);
        chk("pre_rst ex_valid", int'(ex_valid_o), 1);
        #2 rst_i = 1'b1;
        #1;
        chk_all("async_rst", 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("post_rst stall", int'(stall_o), 0);
        chk("post_rst issue", int'(issue_o), 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst ex_valid", int'(ex_valid_o), 1);
        chk("post_rst fwd_a", int'(fwd_a_o), 0);
        chk("post_rst fwd_b", int'(fwd_b_o), 0);

`ifdef HAZARD_MC_UNIT_EN
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 23, 1, 0, 0);
        mc_d_i = 1'b1;
        mc_lat_d_i = 4'd3;
        #1;
        chk("mc_issue issue", int'(issue_o), 1);
        chk("mc_issue busy", int'(mc_busy_o), 0);
        @(negedge clk);
        drive(1, 23, 0, 1, 0, 25, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mc_cyc%0d busy", c), int'(mc_busy_o), 1);
            chk($sformatf("mc_cyc%0d stall", c), int'(stall_o), 1);
            chk($sformatf("mc_cyc%0d issue", c), int'(issue_o), 0);
            @(negedge clk);
        end
        #1;
        chk("mc_done busy", int'(mc_busy_o), 0);
        chk("mc_done stall", int'(stall_o), 0);
        chk("mc_done issue", int'(issue_o), 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mc_dep ex_valid", int'(ex_valid_o), 1);
        chk("mc_dep fwd_a", int'(fwd_a_o), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
